// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one
// operation in flight at a time.
//
// IDLE accepts one request (req_ready is combinational in that cycle) and
// latches its opcode, operands and PC. EXEC holds the latched values on the
// alu_* outputs for EXEC_CYCLES cycles and then captures alu_result/alu_nxtpc.
// RESP presents the captured data to the granted requester until its
// rsp_ready is seen.
//
// Build option: define ALU_ARB_RR_EN for round-robin arbitration between
// simultaneous requests. Without it, requester 0 always wins a tie and no
// pointer register exists.
//
// Parameters:
//   EXEC_CYCLES  cycles spent in EXEC before result capture (1..15)
//   OpWidth      opcode width
//   WordWidth    operand / PC width
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid_N, req_ready_N      request handshake, requester N
//   req_op_N, req_a_N, req_b_N,
//   req_pc_N                      request payload, requester N
//   alu_operator, alu_arg_a,
//   alu_arg_b, alu_currpc         latched operation driven to the shared ALU
//   alu_result, alu_nxtpc         ALU outputs
//   rsp_valid_N, rsp_ready_N      response handshake, requester N
//   rsp_result, rsp_nxtpc         captured response data (shared)
//   busy                          high in any state other than IDLE
//   grant_id                      requester owning the ALU

module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned OpWidth     = 4,
  parameter int unsigned WordWidth   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_0,
  input  logic                 req_valid_1,
  output logic                 req_ready_0,
  output logic                 req_ready_1,
  input  logic [OpWidth-1:0]   req_op_0,
  input  logic [OpWidth-1:0]   req_op_1,
  input  logic [WordWidth-1:0] req_a_0,
  input  logic [WordWidth-1:0] req_b_0,
  input  logic [WordWidth-1:0] req_pc_0,
  input  logic [WordWidth-1:0] req_a_1,
  input  logic [WordWidth-1:0] req_b_1,
  input  logic [WordWidth-1:0] req_pc_1,
  output logic [OpWidth-1:0]   alu_operator,
  output logic [WordWidth-1:0] alu_arg_a,
  output logic [WordWidth-1:0] alu_arg_b,
  output logic [WordWidth-1:0] alu_currpc,
  input  logic [WordWidth-1:0] alu_result,
  input  logic [WordWidth-1:0] alu_nxtpc,
  output logic                 rsp_valid_0,
  output logic                 rsp_valid_1,
  input  logic                 rsp_ready_0,
  input  logic                 rsp_ready_1,
  output logic [WordWidth-1:0] rsp_result,
  output logic [WordWidth-1:0] rsp_nxtpc,
  output logic                 busy,
  output logic                 grant_id
);

  localparam int unsigned CntWidth = 4;
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e                 state_q;
  logic [OpWidth-1:0]     op_q;
  logic [WordWidth-1:0]   a_q;
  logic [WordWidth-1:0]   b_q;
  logic [WordWidth-1:0]   pc_q;
  logic [CntWidth-1:0]    cnt_q;
  logic                   grant_q;
  logic                   busy_q;
  logic                   rsp_valid_0_q;
  logic                   rsp_valid_1_q;
  logic [WordWidth-1:0]   rsp_result_q;
  logic [WordWidth-1:0]   rsp_nxtpc_q;

  logic any_req;
  logic accept;
  logic pick;
  logic rsp_take;

  assign any_req = req_valid_0 | req_valid_1;
  assign accept  = (state_q == StIdle) && any_req;

`ifdef ALU_ARB_RR_EN
  // Requester favoured on the next tie; always the one not granted last.
  logic rr_ptr_q;

  always_comb begin
    pick = req_valid_1;
    if (req_valid_0 && req_valid_1) begin
      pick = rr_ptr_q;
    end
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is idle.
  always_comb begin
    pick = 1'b0;
    if (!req_valid_0) begin
      pick = req_valid_1;
    end
  end
`endif

  assign req_ready_0 = accept && !pick;
  assign req_ready_1 = accept && pick;

  // Only the granted requester can complete the response handshake.
  assign rsp_take = grant_q ? rsp_ready_1 : rsp_ready_0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      pc_q          <= '0;
      cnt_q         <= '0;
      grant_q       <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      rsp_result_q  <= '0;
      rsp_nxtpc_q   <= '0;
`ifdef ALU_ARB_RR_EN
      rr_ptr_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            op_q    <= pick ? req_op_1 : req_op_0;
            a_q     <= pick ? req_a_1  : req_a_0;
            b_q     <= pick ? req_b_1  : req_b_0;
            pc_q    <= pick ? req_pc_1 : req_pc_0;
            grant_q <= pick;
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
            state_q <= StExec;
`ifdef ALU_ARB_RR_EN
            rr_ptr_q <= ~pick;
`endif
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            rsp_result_q  <= alu_result;
            rsp_nxtpc_q   <= alu_nxtpc;
            rsp_valid_0_q <= ~grant_q;
            rsp_valid_1_q <= grant_q;
            state_q       <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (rsp_take) begin
            // Clearing the operands returns the alu_* outputs to zero in IDLE.
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            pc_q          <= '0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign alu_operator = op_q;
  assign alu_arg_a    = a_q;
  assign alu_arg_b    = b_q;
  assign alu_currpc   = pc_q;
  assign rsp_valid_0  = rsp_valid_0_q;
  assign rsp_valid_1  = rsp_valid_1_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_nxtpc    = rsp_nxtpc_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;

endmodule
